// File: rtl/oqpsk_tx_if.sv
// Chip handshake and sample output bundle for the O-QPSK transmit shaper.
interface oqpsk_tx_if #(
  parameter int OUT_W = 8
);
  logic                    i_chip_valid;
  logic [1:0]              i_chip;
  logic                    o_chip_ready;
  logic signed [OUT_W-1:0] o_i;
  logic signed [OUT_W-1:0] o_q;
  logic                    o_sample_valid;

  modport master (
    output i_chip_valid, i_chip,
    input  o_chip_ready, o_i, o_q, o_sample_valid
  );

  modport slave (
    input  i_chip_valid, i_chip,
    output o_chip_ready, o_i, o_q, o_sample_valid
  );
endinterface

// File: rtl/oqpsk_tx_shaper.sv
// O-QPSK transmit chip timing and pulse shaper: P samples per chip, Q rail offset by P/2.
// Macro TX_PULSE_SHAPING_EN selects triangular pulses; without it pulses are rectangular NRZ of height P/2.
module oqpsk_tx_shaper #(
  parameter int OUT_W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_nb_P,
  input  logic       i_ce,
  oqpsk_tx_if.slave  bus,
  output logic       o_busy,
  output logic       o_frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e state_q, state_d;
  logic [5:0] p_q, p_d;
  logic [5:0] k_q, k_d;
  logic ireg_q, ireg_d, qpend_q, qpend_d, qreg_q, qreg_d;
  logic iact_q, iact_d, qact_q, qact_d;
  logic signed [OUT_W-1:0] oi_q, oi_d, oq_q, oq_d;
  logic vld_q, done_q;
  logic emit, done, ready;
  logic [5:0] h, nb_even, p_new, s_i, s_q;
  logic signed [OUT_W-1:0] mag_i, mag_q;

  assign h       = p_q >> 1;
  assign nb_even = i_nb_P & 6'h3E;
  assign p_new   = (nb_even < 6'd4) ? 6'd4 : nb_even;

`ifdef TX_PULSE_SHAPING_EN
  logic [5:0] kq;
  // Q phase wraps half a chip ahead of I; in DRAIN k<H so the first branch applies.
  assign kq  = (k_q < h) ? k_q + h : k_q - h;
  assign s_i = (k_q <= h) ? k_q : p_q - k_q;
  assign s_q = (kq <= h) ? kq : p_q - kq;
`else
  assign s_i = h;
  assign s_q = h;
`endif

  assign mag_i = {{(OUT_W-6){1'b0}}, s_i};
  assign mag_q = {{(OUT_W-6){1'b0}}, s_q};
  assign oi_d  = iact_q ? (ireg_q ? mag_i : -mag_i) : '0;
  assign oq_d  = qact_q ? (qreg_q ? mag_q : -mag_q) : '0;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    k_d     = k_q;
    ireg_d  = ireg_q;
    qpend_d = qpend_q;
    qreg_d  = qreg_q;
    iact_d  = iact_q;
    qact_d  = qact_q;
    emit    = 1'b0;
    done    = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.i_chip_valid) begin
          p_d     = p_new;
          ireg_d  = bus.i_chip[0];
          qpend_d = bus.i_chip[1];
          iact_d  = 1'b1;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_ce) begin
          emit = 1'b1;
          k_d  = k_q + 6'd1;
          if (k_q == h - 6'd1) begin
            qreg_d = qpend_q;
            qact_d = 1'b1;
          end
          // End of chip: the strobe that emits k=P-1 also accepts the next chip gaplessly.
          if (k_q == p_q - 6'd1) begin
            ready = 1'b1;
            k_d   = '0;
            if (bus.i_chip_valid) begin
              ireg_d  = bus.i_chip[0];
              qpend_d = bus.i_chip[1];
            end else begin
              iact_d  = 1'b0;
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (i_ce) begin
          emit = 1'b1;
          k_d  = k_q + 6'd1;
          if (k_q == h - 6'd1) begin
            qact_d  = 1'b0;
            k_d     = '0;
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      k_q     <= '0;
      ireg_q  <= 1'b0;
      qpend_q <= 1'b0;
      qreg_q  <= 1'b0;
      iact_q  <= 1'b0;
      qact_q  <= 1'b0;
      oi_q    <= '0;
      oq_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      k_q     <= k_d;
      ireg_q  <= ireg_d;
      qpend_q <= qpend_d;
      qreg_q  <= qreg_d;
      iact_q  <= iact_d;
      qact_q  <= qact_d;
      vld_q   <= emit;
      done_q  <= done;
      if (emit) begin
        oi_q <= oi_d;
        oq_q <= oq_d;
      end
    end
  end

  assign bus.o_chip_ready   = ready;
  assign bus.o_i            = oi_q;
  assign bus.o_q            = oq_q;
  assign bus.o_sample_valid = vld_q;
  assign o_busy             = (state_q != IDLE);
  assign o_frame_done       = done_q;

endmodule

// File: tb/tb_oqpsk_tx_shaper.sv
// Directed table-driven bench for oqpsk_tx_shaper; expected samples follow the TX_PULSE_SHAPING_EN build.
module tb_oqpsk_tx_shaper;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_nb_P;
  logic       i_ce;
  logic       o_busy;
  logic       o_frame_done;

  oqpsk_tx_if #(.OUT_W(8)) bus ();

  oqpsk_tx_shaper #(.OUT_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_nb_P       (i_nb_P),
    .i_ce         (i_ce),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] c0;
    logic [1:0] c1;
    int         nch;
    logic [5:0] nb;
    logic [5:0] nb_mid;
    int         div;
    int         n;
    int         off;
  } vec_t;

  // Expected sample streams, concatenated: A(0,12) B(12,12) C(24,20) D(44,9) E(53,6)
`ifdef TX_PULSE_SHAPING_EN
  int EXP_I [59] = '{
    0,1,2,3,4,3,2,1,0,0,0,0,
    0,1,2,3,4,3,2,1,0,0,0,0,
    0,-1,-2,-3,-4,-3,-2,-1,0,1,2,3,4,3,2,1,0,0,0,0,
    0,1,2,3,2,1,0,0,0,
    0,-1,-2,-1,0,0};
  int EXP_Q [59] = '{
    0,0,0,0,0,-1,-2,-3,-4,-3,-2,-1,
    0,0,0,0,0,1,2,3,4,3,2,1,
    0,0,0,0,0,1,2,3,4,3,2,1,0,-1,-2,-3,-4,-3,-2,-1,
    0,0,0,0,1,2,3,2,1,
    0,0,0,1,2,1};
`else
  int EXP_I [59] = '{
    4,4,4,4,4,4,4,4,0,0,0,0,
    4,4,4,4,4,4,4,4,0,0,0,0,
    -4,-4,-4,-4,-4,-4,-4,-4,4,4,4,4,4,4,4,4,0,0,0,0,
    3,3,3,3,3,3,0,0,0,
    -2,-2,-2,-2,0,0};
  int EXP_Q [59] = '{
    0,0,0,0,-4,-4,-4,-4,-4,-4,-4,-4,
    0,0,0,0,4,4,4,4,4,4,4,4,
    0,0,0,0,4,4,4,4,4,4,4,4,-4,-4,-4,-4,-4,-4,-4,-4,
    0,0,0,3,3,3,3,3,3,
    0,0,2,2,2,2};
`endif

  int nchk = 0;
  int nerr = 0;
  int gcyc = 0;
  int fd_total = 0;
  int cap_i[$];
  int cap_q[$];
  int cap_t[$];
  bit cap_fd[$];

  always @(posedge i_clk) gcyc <= gcyc + 1;

  always @(negedge i_clk) begin
    if (bus.o_sample_valid) begin
      cap_i.push_back(int'(bus.o_i));
      cap_q.push_back(int'(bus.o_q));
      cap_t.push_back(gcyc);
      cap_fd.push_back(o_frame_done);
    end
    if (o_frame_done) fd_total++;
  end

  task automatic chk(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int  cyc, idx, base, n, m, rdy_cnt, rdy_bad;
    bit  acc, done;
    cyc = 0; idx = 0; done = 0; rdy_cnt = 0; rdy_bad = 0;
    base = cap_i.size();
    i_nb_P = v.nb;
    bus.i_chip = v.c0;
    bus.i_chip_valid = 1'b1;
    while (!done && cyc < 2000) begin
      i_ce = ((cyc % v.div) == 0);
      #1;
      if (o_busy && bus.o_chip_ready) begin
        rdy_cnt++;
        if (!i_ce) rdy_bad++;
      end
      acc = bus.i_chip_valid && bus.o_chip_ready;
      @(posedge i_clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx == 1) i_nb_P = v.nb_mid;
        if (idx < v.nch) bus.i_chip = v.c1;
        else bus.i_chip_valid = 1'b0;
      end
      if (o_frame_done) done = 1;
    end
    i_ce = 1'b0;
    bus.i_chip_valid = 1'b0;
    @(negedge i_clk); #1;
    chk($sformatf("v%0d frame_done_seen", id), int'(done), 1);
    n = cap_i.size() - base;
    chk($sformatf("v%0d nsamples", id), n, v.n);
    m = (n < v.n) ? n : v.n;
    for (int j = 0; j < m; j++) begin
      chk($sformatf("v%0d o_i[%0d]", id, j), cap_i[base+j], EXP_I[v.off+j]);
      chk($sformatf("v%0d o_q[%0d]", id, j), cap_q[base+j], EXP_Q[v.off+j]);
      chk($sformatf("v%0d frame_done[%0d]", id, j), int'(cap_fd[base+j]), int'(j == n-1));
      if (j > 0)
        chk($sformatf("v%0d cadence[%0d]", id, j), cap_t[base+j] - cap_t[base+j-1], v.div);
    end
    chk($sformatf("v%0d ready_strobes", id), rdy_cnt, v.nch);
    chk($sformatf("v%0d ready_off_strobe", id), rdy_bad, 0);
    chk($sformatf("v%0d busy_after", id), int'(o_busy), 0);
    chk($sformatf("v%0d ready_after", id), int'(bus.o_chip_ready), 1);
  endtask

  vec_t vecs [6];

  initial begin
    int base, fd0;
    vecs[0] = '{2'b01, 2'b01, 1, 6'd8,  6'd8,  1, 12, 0};
    vecs[1] = '{2'b11, 2'b11, 1, 6'd8,  6'd8,  3, 12, 12};
    vecs[2] = '{2'b10, 2'b01, 2, 6'd8,  6'd8,  4, 20, 24};
    vecs[3] = '{2'b11, 2'b11, 1, 6'd7,  6'd7,  1, 9,  44};
    vecs[4] = '{2'b10, 2'b10, 1, 6'd2,  6'd2,  2, 6,  53};
    vecs[5] = '{2'b11, 2'b11, 1, 6'd8,  6'd20, 1, 12, 12};

    i_rst = 1'b1;
    i_ce = 1'b0;
    i_nb_P = 6'd8;
    bus.i_chip_valid = 1'b0;
    bus.i_chip = 2'b00;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset o_i", int'(bus.o_i), 0);
    chk("reset o_q", int'(bus.o_q), 0);
    chk("reset sample_valid", int'(bus.o_sample_valid), 0);
    chk("reset busy", int'(o_busy), 0);
    chk("reset frame_done", int'(o_frame_done), 0);
    chk("reset chip_ready", int'(bus.o_chip_ready), 1);
    i_rst = 1'b0;

    // Strobes while idle must not produce samples
    i_ce = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    chk("idle ce samples", cap_i.size(), 0);
    chk("idle ce busy", int'(o_busy), 0);
    i_ce = 1'b0;

    for (int v = 0; v < 6; v++) run_vec(v, vecs[v]);

    // Reset in RUN at k=3: in-flight chip dropped, no frame_done
    base = cap_i.size();
    i_nb_P = 6'd8;
    bus.i_chip = 2'b11;
    bus.i_chip_valid = 1'b1;
    i_ce = 1'b1;
    @(posedge i_clk); #1;
    bus.i_chip_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("pre-reset busy", int'(o_busy), 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("midrst o_i", int'(bus.o_i), 0);
    chk("midrst o_q", int'(bus.o_q), 0);
    chk("midrst sample_valid", int'(bus.o_sample_valid), 0);
    chk("midrst busy", int'(o_busy), 0);
    chk("midrst frame_done", int'(o_frame_done), 0);
    chk("midrst chip_ready", int'(bus.o_chip_ready), 1);
    i_rst = 1'b0;
    fd0 = fd_total;
    repeat (8) @(posedge i_clk);
    #1;
    chk("midrst samples", cap_i.size() - base, 3);
    chk("midrst no frame_done", fd_total - fd0, 0);
    chk("midrst idle busy", int'(o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
